// File: rtl/maxpool3_window_gen.sv
`default_nettype none
// ============================================================================
// maxpool3_window_gen : 3x3 strided window source for the pipelined max-pool
// tree. Optional synchronous clear port enabled by MAXPOOL_SYNC_CLR_EN.
// Revision: 1.0
// ============================================================================
module maxpool3_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int STRIDE     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MAXPOOL_SYNC_CLR_EN
  input  logic                  clr,
`endif
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] o_i1,
  output logic [DATA_WIDTH-1:0] o_i2,
  output logic [DATA_WIDTH-1:0] o_i3,
  output logic [DATA_WIDTH-1:0] o_i4,
  output logic [DATA_WIDTH-1:0] o_i5,
  output logic [DATA_WIDTH-1:0] o_i6,
  output logic [DATA_WIDTH-1:0] o_i7,
  output logic [DATA_WIDTH-1:0] o_i8,
  output logic [DATA_WIDTH-1:0] o_i9,
  output logic                  win_valid,
  output logic [2:0]            stage_en,
  output logic                  result_valid,
  output logic                  frame_done
);

  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);
  localparam int PH_W     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int LAST_ROW = 2 + ((IMG_H - 3) / STRIDE) * STRIDE;
  localparam int LAST_COL = 2 + ((IMG_W - 3) / STRIDE) * STRIDE;

  localparam logic [COL_W-1:0] c_col_max  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] c_row_max  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] c_col_two  = COL_W'(2);
  localparam logic [ROW_W-1:0] c_row_two  = ROW_W'(2);
  localparam logic [COL_W-1:0] c_col_last = COL_W'(LAST_COL);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(LAST_ROW);
  localparam logic [PH_W-1:0]  c_ph_max   = PH_W'(STRIDE - 1);

  logic                  w_clr;
  logic                  w_accept;
  logic                  w_emit;
  logic                  w_last;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [PH_W-1:0]       r_col_ph;
  logic [PH_W-1:0]       r_row_ph;
  logic [PH_W-1:0]       w_col_ph_nxt;
  logic [PH_W-1:0]       w_row_ph_nxt;
  logic [DATA_WIDTH-1:0] r_lb1 [IMG_W];
  logic [DATA_WIDTH-1:0] r_lb2 [IMG_W];
  logic [DATA_WIDTH-1:0] w_lb1_rd;
  logic [DATA_WIDTH-1:0] w_lb2_rd;
  logic [DATA_WIDTH-1:0] r_win [9];
  logic [DATA_WIDTH-1:0] r_i9_d;
  logic [3:0]            r_fd_pipe;

`ifdef MAXPOOL_SYNC_CLR_EN
  assign w_clr = clr;
`else
  assign w_clr = 1'b0;
`endif

  assign w_accept = in_valid & ~w_clr;
  assign w_lb1_rd = r_lb1[r_col];
  assign w_lb2_rd = r_lb2[r_col];

  // Phase is (pos-2) mod STRIDE, pinned to 0 for positions 0..2
  assign w_col_ph_nxt = (r_col < c_col_two) ? '0 :
                        (r_col_ph == c_ph_max) ? '0 : r_col_ph + 1'b1;
  assign w_row_ph_nxt = (r_row < c_row_two) ? '0 :
                        (r_row_ph == c_ph_max) ? '0 : r_row_ph + 1'b1;

  assign w_emit = w_accept && (r_row >= c_row_two) && (r_col >= c_col_two) &&
                  (r_col_ph == '0) && (r_row_ph == '0);
  assign w_last = (r_row == c_row_last) && (r_col == c_col_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_col_ph <= '0;
      r_row_ph <= '0;
    end else if (w_clr) begin
      r_col    <= '0;
      r_row    <= '0;
      r_col_ph <= '0;
      r_row_ph <= '0;
    end else if (w_accept) begin
      if (r_col == c_col_max) begin
        r_col    <= '0;
        r_col_ph <= '0;
        if (r_row == c_row_max) begin
          r_row    <= '0;
          r_row_ph <= '0;
        end else begin
          r_row    <= r_row + 1'b1;
          r_row_ph <= w_row_ph_nxt;
        end
      end else begin
        r_col    <= r_col + 1'b1;
        r_col_ph <= w_col_ph_nxt;
      end
    end
  end

  // Read-before-write: the old LB1 entry ages into LB2 at the same column
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb2[r_col] <= w_lb1_rd;
      r_lb1[r_col] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      {o_i1, o_i2, o_i3, o_i4, o_i5, o_i6, o_i7, o_i8} <= '0;
      r_i9_d       <= '0;
      o_i9         <= '0;
      win_valid    <= 1'b0;
      stage_en     <= '0;
      result_valid <= 1'b0;
      r_fd_pipe    <= '0;
      frame_done   <= 1'b0;
    end else if (w_clr) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      {o_i1, o_i2, o_i3, o_i4, o_i5, o_i6, o_i7, o_i8} <= '0;
      r_i9_d       <= '0;
      o_i9         <= '0;
      win_valid    <= 1'b0;
      stage_en     <= '0;
      result_valid <= 1'b0;
      r_fd_pipe    <= '0;
      frame_done   <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r*3]   <= r_win[r*3+1];
          r_win[r*3+1] <= r_win[r*3+2];
        end
        r_win[2] <= w_lb2_rd;
        r_win[5] <= w_lb1_rd;
        r_win[8] <= in_data;
      end
      // Operands are taken from the post-shift window, i.e. the same edge's next state
      if (w_emit) begin
        o_i1 <= r_win[1];
        o_i2 <= r_win[2];
        o_i3 <= w_lb2_rd;
        o_i4 <= r_win[4];
        o_i5 <= r_win[5];
        o_i6 <= w_lb1_rd;
        o_i7 <= r_win[7];
        o_i8 <= r_win[8];
      end
      r_i9_d       <= r_win[8];
      o_i9         <= r_i9_d;
      win_valid    <= w_emit;
      stage_en     <= {stage_en[1:0], win_valid};
      result_valid <= stage_en[2];
      r_fd_pipe    <= {r_fd_pipe[2:0], w_emit & w_last};
      frame_done   <= r_fd_pipe[3];
    end
  end

endmodule
`default_nettype wire
